// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory-port signals around the shared memory arbiter.
// The arbiter takes the slave view; the pipeline/memory environment takes the master view.
interface mem_port_arbiter_if #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 16
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic          m_en;
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata;
  logic [DW-1:0] m_rdata;
  logic          if_stall;
  logic          d_stall;
  logic          busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    output if_ack, if_rdata, d_ack, d_rdata, m_en, m_we, m_addr, m_wdata,
           if_stall, d_stall, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
    input  if_ack, if_rdata, d_ack, d_rdata, m_en, m_we, m_addr, m_wdata,
           if_stall, d_stall, busy
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch (read-only) and data (read/write) requesters.
// Data wins contention until it has won STARVE_MAX times in a row over a waiting fetch.
module mem_port_arbiter #(
  parameter int unsigned AW         = 16,
  parameter int unsigned DW         = 16,
  parameter int unsigned LAT        = 1,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  mem_port_arbiter_if.slave    bus
);

  localparam logic [2:0] StarveMax = 3'(STARVE_MAX);
  localparam logic [1:0] WaitInit  = 2'(LAT - 1);

  typedef enum logic [1:0] {StIdle, StAccess, StWait, StResp} state_e;

  state_e        state_q;
  logic          gnt_d_q;
  logic [2:0]    streak_q;
  logic [1:0]    wcnt_q;
  logic          m_en_q;
  logic          m_we_q;
  logic [AW-1:0] m_addr_q;
  logic [DW-1:0] m_wdata_q;
  logic          if_ack_q;
  logic          d_ack_q;
  logic [DW-1:0] if_rdata_q;
  logic [DW-1:0] d_rdata_q;

  logic       grant_d;
  logic [2:0] streak_d;

  always_comb begin
    grant_d  = bus.d_req && !(bus.if_req && (streak_q == StarveMax));
    streak_d = '0;
    // Only data grants that bypass a waiting fetch count toward starvation.
    if (grant_d && bus.if_req) begin
      streak_d = (streak_q >= StarveMax) ? StarveMax : streak_q + 3'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      gnt_d_q    <= 1'b0;
      streak_q   <= '0;
      wcnt_q     <= '0;
      m_en_q     <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.if_req || bus.d_req) begin
            state_q   <= StAccess;
            gnt_d_q   <= grant_d;
            streak_q  <= streak_d;
            m_en_q    <= 1'b1;
            m_we_q    <= grant_d && bus.d_we;
            m_addr_q  <= grant_d ? bus.d_addr : bus.if_addr;
            if (grant_d) m_wdata_q <= bus.d_wdata;
          end
        end
        StAccess: begin
          m_en_q <= 1'b0;
          m_we_q <= 1'b0;
          if (m_we_q) begin
            state_q <= StResp;
            d_ack_q <= 1'b1;
          end else begin
            state_q <= StWait;
            wcnt_q  <= WaitInit;
          end
        end
        StWait: begin
          // The last wait cycle is the one in which m_rdata is valid.
          if (wcnt_q == '0) begin
            state_q <= StResp;
            if (gnt_d_q) begin
              d_rdata_q <= bus.m_rdata;
              d_ack_q   <= 1'b1;
            end else begin
              if_rdata_q <= bus.m_rdata;
              if_ack_q   <= 1'b1;
            end
          end else begin
            wcnt_q <= wcnt_q - 2'd1;
          end
        end
        StResp: begin
          state_q  <= StIdle;
          if_ack_q <= 1'b0;
          d_ack_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.m_en     = m_en_q;
  assign bus.m_we     = m_we_q;
  assign bus.m_addr   = m_addr_q;
  assign bus.m_wdata  = m_wdata_q;
  assign bus.if_ack   = if_ack_q;
  assign bus.d_ack    = d_ack_q;
  assign bus.if_rdata = if_rdata_q;
  assign bus.d_rdata  = d_rdata_q;
  assign bus.if_stall = bus.if_req & ~if_ack_q;
  assign bus.d_stall  = bus.d_req & ~d_ack_q;
  assign bus.busy     = (state_q != StIdle);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with LAT=1, one with LAT=3,
// each backed by a small latency-accurate memory model.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(16), .DW(16)) b1 ();
  mem_port_arbiter_if #(.AW(16), .DW(16)) b3 ();

  mem_port_arbiter #(.AW(16), .DW(16), .LAT(1), .STARVE_MAX(3)) u1 (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (b1)
  );

  mem_port_arbiter #(.AW(16), .DW(16), .LAT(3), .STARVE_MAX(3)) u3 (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (b3)
  );

  function automatic logic [15:0] data_of(input logic [15:0] a);
    case (a)
      16'h0010: data_of = 16'hA5A5;
      16'h0040: data_of = 16'h7777;
      16'h0050: data_of = 16'h1111;
      16'h0060: data_of = 16'h6060;
      16'h0070: data_of = 16'h7070;
      16'h0080: data_of = 16'h4242;
      16'h0300: data_of = 16'hBEEF;
      default:  data_of = ~a;
    endcase
  endfunction

  // Read data is presented only in the cycle exactly LAT after m_en; DEAD otherwise.
  logic        v1 = 1'b0;
  logic [15:0] d1 = '0;
  logic        v3a = 1'b0, v3b = 1'b0, v3c = 1'b0;
  logic [15:0] d3a = '0, d3b = '0, d3c = '0;

  always @(posedge clk) begin
    v1  <= b1.m_en & ~b1.m_we;
    d1  <= data_of(b1.m_addr);
    v3a <= b3.m_en & ~b3.m_we;
    d3a <= data_of(b3.m_addr);
    v3b <= v3a;
    d3b <= d3a;
    v3c <= v3b;
    d3c <= d3b;
  end

  assign b1.m_rdata = v1  ? d1  : 16'hDEAD;
  assign b3.m_rdata = v3c ? d3c : 16'hDEAD;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          en_cnt;
    int          ack_at;
    int          n;
    int          last_t;
    logic [7:0]  kinds;
    logic [7:0]  exp_kinds;
    logic [15:0] rdata_at_ack;

    b1.if_req = 0; b1.if_addr = '0; b1.d_req = 0; b1.d_we = 0; b1.d_addr = '0; b1.d_wdata = '0;
    b3.if_req = 0; b3.if_addr = '0; b3.d_req = 0; b3.d_we = 0; b3.d_addr = '0; b3.d_wdata = '0;

    // Reset state
    step(); step();
    chk("rst_m_en", 32'(b1.m_en), 0);
    chk("rst_busy", 32'(b1.busy), 0);
    chk("rst_acks", {30'd0, b1.if_ack, b1.d_ack}, 0);
    chk("rst_m_addr", 32'(b1.m_addr), 0);
    chk("rst_rdata", {b1.if_rdata, b1.d_rdata}, 0);
    rst_n = 1'b1;
    step();

    // Single fetch, LAT=1
    b1.if_req = 1; b1.if_addr = 16'h0010;
    #1;
    chk("f_stall_t0", 32'(b1.if_stall), 1);
    step();
    chk("f_m_en_t1", {30'd0, b1.m_en, b1.m_we}, 32'b10);
    chk("f_m_addr_t1", 32'(b1.m_addr), 32'h0010);
    chk("f_busy_t1", 32'(b1.busy), 1);
    step();
    chk("f_m_en_t2", 32'(b1.m_en), 0);
    chk("f_ack_t2", 32'(b1.if_ack), 0);
    chk("f_stall_t2", 32'(b1.if_stall), 1);
    step();
    chk("f_ack_t3", 32'(b1.if_ack), 1);
    chk("f_rdata_t3", 32'(b1.if_rdata), 32'hA5A5);
    chk("f_stall_t3", 32'(b1.if_stall), 0);
    b1.if_req = 0;
    step();
    chk("f_ack_t4", 32'(b1.if_ack), 0);
    chk("f_idle_t4", 32'(b1.busy), 0);

    // Data write, LAT=1
    b1.d_req = 1; b1.d_we = 1; b1.d_addr = 16'h0200; b1.d_wdata = 16'h1234;
    step();
    chk("w_m_en_we_t1", {30'd0, b1.m_en, b1.m_we}, 32'b11);
    chk("w_m_addr_t1", 32'(b1.m_addr), 32'h0200);
    chk("w_m_wdata_t1", 32'(b1.m_wdata), 32'h1234);
    chk("w_ack_t1", 32'(b1.d_ack), 0);
    step();
    chk("w_ack_t2", 32'(b1.d_ack), 1);
    chk("w_m_en_t2", {30'd0, b1.m_en, b1.m_we}, 0);
    b1.d_req = 0; b1.d_we = 0;
    step();
    chk("w_ack_t3", 32'(b1.d_ack), 0);
    chk("w_idle_t3", 32'(b1.busy), 0);

    // Read latency, LAT=3
    b3.d_req = 1; b3.d_we = 0; b3.d_addr = 16'h0300;
    en_cnt = 0; ack_at = -1; rdata_at_ack = '0;
    for (int k = 1; k <= 7; k++) begin
      step();
      en_cnt += int'(b3.m_en);
      if (b3.d_ack) begin
        ack_at = k;
        rdata_at_ack = b3.d_rdata;
        b3.d_req = 0;
      end
    end
    b3.d_req = 0;
    chk("l3_ack_cycle", 32'(ack_at), 5);
    chk("l3_m_en_cycles", 32'(en_cnt), 1);
    chk("l3_rdata", 32'(rdata_at_ack), 32'hBEEF);
    chk("l3_rdata_hold", 32'(b3.d_rdata), 32'hBEEF);

    // Simultaneous first request, data first
    b1.if_req = 1; b1.if_addr = 16'h0040;
    b1.d_req = 1; b1.d_we = 0; b1.d_addr = 16'h0050;
    step();
    chk("s_m_addr_t1", 32'(b1.m_addr), 32'h0050);
    step(); step();
    chk("s_d_ack_t3", {30'd0, b1.d_ack, b1.if_ack}, 32'b10);
    chk("s_d_rdata_t3", 32'(b1.d_rdata), 32'h1111);
    chk("s_if_rdata_kept", 32'(b1.if_rdata), 32'hA5A5);
    b1.d_req = 0;
    step();
    chk("s_m_en_t4", 32'(b1.m_en), 0);
    step();
    chk("s_f_m_en_t5", 32'(b1.m_en), 1);
    chk("s_f_m_addr_t5", 32'(b1.m_addr), 32'h0040);
    step(); step();
    chk("s_f_ack_t7", 32'(b1.if_ack), 1);
    chk("s_f_rdata_t7", 32'(b1.if_rdata), 32'h7777);
    b1.if_req = 0;
    step();

    // Contention: grant order and spacing
    b1.if_req = 1; b1.if_addr = 16'h0060;
    b1.d_req = 1; b1.d_we = 0; b1.d_addr = 16'h0070;
    n = 0; kinds = '0; last_t = 0;
    for (int k = 1; k <= 60 && n < 8; k++) begin
      step();
      if (b1.d_ack || b1.if_ack) begin
        kinds[7-n] = b1.d_ack;
        if (n > 0) chk("c_ack_spacing", 32'(k - last_t), 4);
        last_t = k;
        n++;
      end
    end
    b1.if_req = 0; b1.d_req = 0;
    exp_kinds = 8'b1110_1110;
    chk("c_ack_count", 32'(n), 8);
    chk("c_grant_order", 32'(kinds), 32'(exp_kinds));
    step(); step();

    // Reset mid-access during WAIT, LAT=3
    b3.if_req = 1; b3.if_addr = 16'h0080;
    step(); step();
    rst_n = 1'b0;
    #1;
    chk("r_m_en", {30'd0, b3.m_en, b3.m_we}, 0);
    chk("r_busy", 32'(b3.busy), 0);
    chk("r_acks", {30'd0, b3.if_ack, b3.d_ack}, 0);
    chk("r_m_addr", 32'(b3.m_addr), 0);
    chk("r_rdata", {b3.if_rdata, b3.d_rdata}, 0);
    step(); step(); step();
    chk("r_no_ack", 32'(b3.if_ack), 0);
    rst_n = 1'b1;
    step();
    chk("r_fresh_m_en", 32'(b3.m_en), 1);
    chk("r_fresh_m_addr", 32'(b3.m_addr), 32'h0080);
    step(); step(); step();
    chk("r_ack_early", 32'(b3.if_ack), 0);
    step();
    chk("r_ack", 32'(b3.if_ack), 1);
    chk("r_rdata_after", 32'(b3.if_rdata), 32'h4242);
    b3.if_req = 0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
